if_fetch_unit: RTL and testbench

Front end of the IF stage. Owns the program counter and issues one instruction fetch at a time to instruction memory over a req/gnt/rvalid handshake. It holds each returned word until the IF stage register accepts it, and redirects on taken branches. It drives PC_out (fetched PC+4) and Instruction_out into the IF stage register, inserting NOP bubbles (32'b0) whenever no instruction is ready.

---
 rtl/if_fetch_unit.sv | 94 +++++++++
 tb/tb_if_fetch_unit.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// IF-stage fetch front end: owns the PC, issues one imem request at a time over req/gnt/rvalid,
// holds the returned word until the IF stage register takes it, and redirects on taken branches.
module if_fetch_unit #(
    parameter int unsigned        ADDR_W   = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              Freeze,
    input  logic              Branch_taken,
    input  logic [ADDR_W-1:0] Branch_addr,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [31:0]       imem_rdata,
    output logic [ADDR_W-1:0] PC_out,
    output logic [31:0]       Instruction_out,
    output logic              Fetch_valid
);

    typedef enum logic [1:0] {StIdle, StReq, StWait, StHold} state_e;

    state_e            state;
    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] held_pc;
    logic [31:0]       held_instr;
    logic              discard;

    logic [ADDR_W-1:0] br_target;
    logic [ADDR_W-1:0] pc_plus4;
    logic              unused_br_lsbs;

    // Instructions are word aligned, so the low target bits carry no information.
    assign br_target      = {Branch_addr[ADDR_W-1:2], 2'b00};
    assign unused_br_lsbs = ^Branch_addr[1:0];
    assign pc_plus4       = fetch_pc + ADDR_W'(4);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= StIdle;
            fetch_pc   <= RESET_PC;
            held_pc    <= '0;
            held_instr <= '0;
            discard    <= 1'b0;
        end else begin
            case (state)
                StIdle: state <= StReq;
                StReq: begin
                    if (Branch_taken) fetch_pc <= br_target;
                    // A redirect in the grant cycle leaves a stale response in flight.
                    if (imem_gnt) begin
                        state   <= StWait;
                        discard <= Branch_taken;
                    end
                end
                StWait: begin
                    if (imem_rvalid) begin
                        discard <= 1'b0;
                        if (Branch_taken) fetch_pc <= br_target;
                        if (discard || Branch_taken) begin
                            state <= StReq;
                        end else begin
                            held_instr <= imem_rdata;
                            held_pc    <= pc_plus4;
                            state      <= StHold;
                        end
                    end else if (Branch_taken) begin
                        discard  <= 1'b1;
                        fetch_pc <= br_target;
                    end
                end
                StHold: begin
                    if (Branch_taken) begin
                        fetch_pc <= br_target;
                        state    <= StReq;
                    end else if (!Freeze) begin
                        fetch_pc <= pc_plus4;
                        state    <= StReq;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    assign imem_req        = (state == StReq);
    assign imem_addr       = fetch_pc;
    assign PC_out          = held_pc;
    // A taken branch squashes the word in the same cycle, before the stage register loads it.
    assign Fetch_valid     = (state == StHold) && !Branch_taken;
    assign Instruction_out = Fetch_valid ? held_instr : 32'h0;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: a behavioural imem with configurable latency plus a
// scoreboard of expected (PC_out, Instruction_out) pairs popped whenever a word is consumed.
module tb_if_fetch_unit;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        Freeze;
    logic        Branch_taken;
    logic [31:0] Branch_addr;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] PC_out;
    logic [31:0] Instruction_out;
    logic        Fetch_valid;

    logic        rst2;
    logic        f2;
    logic        bt2;
    logic [31:0] ba2;
    logic        req2;
    logic [31:0] addr2;
    logic        gnt2;
    logic        rv2;
    logic [31:0] rdata2;
    logic [31:0] pc2;
    logic [31:0] instr2;
    logic        fv2;

    int          n_cmp = 0;
    int          n_bad = 0;
    exp_t        sb[$];
    logic [31:0] gnt_log[$];
    int          deny_n   = 0;
    int          rv_extra = 0;

    if_fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) u_dut (
        .clk             (clk),
        .rst             (rst),
        .Freeze          (Freeze),
        .Branch_taken    (Branch_taken),
        .Branch_addr     (Branch_addr),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_gnt        (imem_gnt),
        .imem_rvalid     (imem_rvalid),
        .imem_rdata      (imem_rdata),
        .PC_out          (PC_out),
        .Instruction_out (Instruction_out),
        .Fetch_valid     (Fetch_valid)
    );

    if_fetch_unit #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFFC)) u_dut2 (
        .clk             (clk),
        .rst             (rst2),
        .Freeze          (f2),
        .Branch_taken    (bt2),
        .Branch_addr     (ba2),
        .imem_req        (req2),
        .imem_addr       (addr2),
        .imem_gnt        (gnt2),
        .imem_rvalid     (rv2),
        .imem_rdata      (rdata2),
        .PC_out          (pc2),
        .Instruction_out (instr2),
        .Fetch_valid     (fv2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'd12) return 32'h2001_0005;
        if (a == 32'd16) return 32'hDEAD_BEEF;
        return {8'hA5, a[23:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [31:0] pc, input logic [31:0] instr);
        exp_t e;
        e.pc    = pc;
        e.instr = instr;
        sb.push_back(e);
    endtask

    // Advance until a real instruction is presented, within a cycle budget.
    task automatic wait_fv(input string tag);
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (Fetch_valid) break;
        end
        chk(tag, 32'(Fetch_valid), 32'd1);
    endtask

    // Memory: grant when not throttled, answer rv_extra+1 cycles after the grant.
    initial begin : mem_model
        logic        rv_pending;
        int          rv_delay;
        int          denied;
        logic [31:0] rv_addr;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        rv_pending  = 1'b0;
        rv_delay    = 0;
        denied      = 0;
        rv_addr     = 32'h0;
        forever begin
            cyc();
            imem_gnt    = 1'b0;
            imem_rvalid = 1'b0;
            if (!rst) begin
                rv_pending = 1'b0;
                denied     = 0;
            end else begin
                if (rv_pending) begin
                    if (rv_delay == 0) begin
                        imem_rvalid = 1'b1;
                        imem_rdata  = mem_word(rv_addr);
                        rv_pending  = 1'b0;
                    end else begin
                        rv_delay--;
                    end
                end
                if (imem_req) begin
                    if (denied < deny_n) begin
                        denied++;
                    end else begin
                        imem_gnt   = 1'b1;
                        rv_pending = 1'b1;
                        rv_delay   = rv_extra;
                        rv_addr    = imem_addr;
                        denied     = 0;
                        gnt_log.push_back(imem_addr);
                    end
                end
            end
        end
    end

    // A word is consumed at any edge where it is presented and the stage is not frozen.
    always @(negedge clk) begin
        if (rst && Fetch_valid && !Freeze) begin
            exp_t e;
            chk("sb_has_entry", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("sb_pc_out", PC_out, e.pc);
                chk("sb_instr", Instruction_out, e.instr);
            end
        end
    end

    initial begin : main
        logic [9:0]  fv_pat;
        logic [9:0]  req_pat;
        logic [31:0] gnt_exp[9];

        rst          = 1'b0;
        Freeze       = 1'b0;
        Branch_taken = 1'b0;
        Branch_addr  = 32'h0;
        rst2         = 1'b0;
        f2           = 1'b0;
        bt2          = 1'b0;
        ba2          = 32'h0;
        gnt2         = 1'b0;
        rv2          = 1'b0;
        rdata2       = 32'h0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_pc_out", PC_out, 32'h0);
        chk("rst_instr", Instruction_out, 32'h0);
        chk("rst_fv", 32'(Fetch_valid), 32'd0);

        // 1: back-to-back fetches, one per three cycles
        push_exp(32'd4, 32'hA500_0000);
        push_exp(32'd8, 32'hA500_0004);
        push_exp(32'd12, 32'hA500_0008);
        push_exp(32'd16, 32'h2001_0005);
        fv_pat  = 10'b1001001000;
        req_pat = 10'b0010010010;
        cyc();
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t1_fv", 32'(Fetch_valid), 32'(fv_pat[i]));
            chk("t1_req", 32'(imem_req), 32'(req_pat[i]));
            if (!fv_pat[i]) chk("t1_bubble", Instruction_out, 32'h0);
        end

        // 2: freeze holds the word for four cycles
        wait_fv("t2_reach_hold");
        rv_extra = 2;
        Freeze   = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t2_fv", 32'(Fetch_valid), 32'd1);
            chk("t2_instr", Instruction_out, 32'h2001_0005);
            chk("t2_pc_out", PC_out, 32'd16);
            chk("t2_no_req", 32'(imem_req), 32'd0);
            cyc();
        end
        Freeze = 1'b0;
        cyc();
        chk("t2_next_req", 32'(imem_req), 32'd1);
        chk("t2_next_addr", imem_addr, 32'd16);

        // 3: redirect while waiting; the late DEADBEEF response must be dropped
        cyc();
        Branch_taken = 1'b1;
        Branch_addr  = 32'h40;
        rv_extra     = 0;
        push_exp(32'h44, 32'hA500_0040);
        @(negedge clk);
        chk("t3_fv_br", 32'(Fetch_valid), 32'd0);
        cyc();
        Branch_taken = 1'b0;
        @(negedge clk);
        chk("t3_fv_w2", 32'(Fetch_valid), 32'd0);
        cyc();
        @(negedge clk);
        chk("t3_fv_drop", 32'(Fetch_valid), 32'd0);
        chk("t3_instr_drop", Instruction_out, 32'h0);
        cyc();
        chk("t3_req", 32'(imem_req), 32'd1);
        chk("t3_addr", imem_addr, 32'h40);
        wait_fv("t3_reach_hold");
        chk("t3_pc_out", PC_out, 32'h44);

        // 4: branch beats freeze in HOLD; squash is combinational
        wait_fv("t4_reach_hold");
        Freeze       = 1'b1;
        Branch_taken = 1'b1;
        Branch_addr  = 32'h203;
        #1;
        chk("t4_squash_instr", Instruction_out, 32'h0);
        chk("t4_squash_fv", 32'(Fetch_valid), 32'd0);
        push_exp(32'h204, 32'hA500_0200);
        cyc();
        Branch_taken = 1'b0;
        Freeze       = 1'b0;
        chk("t4_req", 32'(imem_req), 32'd1);
        chk("t4_addr", imem_addr, 32'h200);
        wait_fv("t4_reach_hold2");
        deny_n = 5;

        // 5: grant withheld five cycles, redirect during the wait for grant
        cyc();
        chk("t5_req_c1", 32'(imem_req), 32'd1);
        chk("t5_addr_c1", imem_addr, 32'h204);
        cyc();
        Branch_taken = 1'b1;
        Branch_addr  = 32'h100;
        chk("t5_addr_c2", imem_addr, 32'h204);
        push_exp(32'h104, 32'hA500_0100);
        for (int c = 0; c < 3; c++) begin
            cyc();
            Branch_taken = 1'b0;
            chk("t5_req_hold", 32'(imem_req), 32'd1);
            chk("t5_addr_new", imem_addr, 32'h100);
        end
        wait_fv("t5_reach_hold");
        deny_n = 0;
        gnt_exp = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h40, 32'h44, 32'h200, 32'h100};
        chk("gnt_log_len", 32'(gnt_log.size() >= 9), 32'd1);
        for (int g = 0; g < 9 && g < gnt_log.size(); g++) chk("gnt_addr", gnt_log[g], gnt_exp[g]);
        cyc();
        Freeze = 1'b1;
        @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        // 6: PC wrap from 0xFFFF_FFFC and asynchronous reset mid-transaction
        chk("t6_rst_addr", addr2, 32'hFFFF_FFFC);
        chk("t6_rst_req", 32'(req2), 32'd0);
        cyc();
        rst2 = 1'b1;
        cyc();
        chk("t6_req1", 32'(req2), 32'd1);
        chk("t6_addr1", addr2, 32'hFFFF_FFFC);
        gnt2 = 1'b1;
        cyc();
        gnt2   = 1'b0;
        rv2    = 1'b1;
        rdata2 = 32'h1111_0013;
        cyc();
        rv2 = 1'b0;
        chk("t6_fv", 32'(fv2), 32'd1);
        chk("t6_pc_wrap", pc2, 32'h0);
        chk("t6_instr", instr2, 32'h1111_0013);
        cyc();
        chk("t6_req2", 32'(req2), 32'd1);
        chk("t6_addr_wrap", addr2, 32'h0);
        gnt2 = 1'b1;
        cyc();
        gnt2 = 1'b0;
        chk("t6_wait_req", 32'(req2), 32'd0);
        rst2 = 1'b0;
        #1;
        chk("t6_async_addr", addr2, 32'hFFFF_FFFC);
        chk("t6_async_req", 32'(req2), 32'd0);
        chk("t6_async_pc", pc2, 32'h0);
        chk("t6_async_instr", instr2, 32'h0);
        chk("t6_async_fv", 32'(fv2), 32'd0);
        cyc();
        rv2    = 1'b1;
        rdata2 = 32'hDEAD_BEEF;
        cyc();
        rv2  = 1'b0;
        rst2 = 1'b1;
        cyc();
        chk("t6_restart_addr", addr2, 32'hFFFF_FFFC);
        chk("t6_restart_fv", 32'(fv2), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
